imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the decode stage.
//  - Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) plus shift-amount and CSR zimm.
//  - Output is XLEN bits wide.
//  - Sits between instruction fetch/decode and the execute stage.
//  - Valid/ready handshake on both sides; a 2-entry skid buffer absorbs execute-side stalls.
// PARAMETERS
//  XLEN  32  datapath width; legal values 32 or 64
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous pipeline flush; discards all held entries
//  in_valid   in   1     Instr/ImmSrc valid
//  in_ready   out  1     block can accept an input this cycle
//  Instr      in   32    instruction word
//  ImmSrc     in   3     immediate format select
//  out_valid  out  1     ImmExt/ImmErr valid
//  out_ready  in   1     consumer accepts output this cycle
//  ImmExt     out  XLEN  extended immediate
//  ImmErr     out  1     ImmSrc was reserved (111)
// BEHAVIOUR
//  Format decode (sext = sign-extend from the MSB shown to XLEN):
//  - 000 I     sext(Instr[31:20])
//  - 001 S     sext({Instr[31:25],Instr[11:7]})
//  - 010 B     sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0})
//  - 011 U     sext({Instr[31:12],12'b0}); for XLEN=64, bits 63:32 copy Instr[31]
//  - 100 J     sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0})
//  - 101 SHAMT zero-extended Instr[24:20] (XLEN=32) or Instr[25:20] (XLEN=64)
//  - 110 ZIMM  zero-extended Instr[19:15]
//  - 111       ImmExt=0, ImmErr=1; every other code gives ImmErr=0
//  Transfers:
//  - Input transfer = in_valid & in_ready.
//  - Output transfer = out_valid & out_ready.
//  - Latency: 1 cycle; a transfer at edge N makes the result visible after edge N when the buffer was empty.
//  Occupancy FSM: EMPTY / ONE / TWO, counting held results. Main register drives the outputs; the skid register sits behind it.
//  - EMPTY: in xfer -> ONE.
//  - ONE:
//    - in xfer with out xfer -> ONE; main register reloads.
//    - in xfer without out xfer -> TWO; result goes to the skid register.
//    - out xfer only -> EMPTY.
//  - TWO:
//    - out xfer -> ONE; skid moves to main.
//    - No input is accepted in TWO.
//  - in_ready = (state != TWO). It is registered-state based, with no combinational path from out_ready.
//  - out_valid = (state != EMPTY).
//  - Order is strictly FIFO. The output is held stable while out_valid & !out_ready.
//  Flush:
//  - flush=1 -> state EMPTY at next edge; out_valid=0 and in_ready=1 after that edge.
//  - An input presented in the flush cycle is dropped.
//  - flush has priority over all simultaneous transfers.
//  Reset (async, any time, including mid-transfer):
//  - state=EMPTY; out_valid=0, in_ready=1, ImmExt=0, ImmErr=0; skid contents cleared to 0.
//  - Release is synchronous to clk.
//  Data registers load only on the transfers above; no X-propagation when in_valid=0.
// TESTING
//  1 XLEN=32, ImmSrc=000, Instr=0xFFF00093 -> after 1 cycle out_valid=1, ImmExt=0xFFFFFFFF, ImmErr=0
//  2 ImmSrc=010, Instr=0xFE000EE3 (beq -4) -> ImmExt=0xFFFFFFFC; ImmSrc=100, Instr=0x0010006F -> ImmExt=0x00000800
//  3 ImmSrc=011: Instr=0x123450B7 -> ImmExt=0x12345000; with XLEN=64, Instr=0x800000B7 -> 0xFFFFFFFF80000000
//  4 Backpressure: out_ready=0, inputs A,B,C held valid back-to-back
//    -> A,B accepted, in_ready=0 from the cycle after B's transfer
//    -> out_ready=1 gives A then B, then C accepted; no loss or reorder
//  5 ImmSrc=111 -> ImmExt=0, ImmErr=1; ImmSrc=101, Instr=0x01F01013 (XLEN=32) -> ImmExt=0x0000001F
//  6 State TWO: assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, dropped input never appears
//    Then assert rst_n=0 mid-transfer -> outputs zero immediately, without waiting for clk

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid buffer
// Main register drives the outputs; the skid register catches one extra result while execute stalls.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmErr
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_main_imm;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_main_err;
  logic            r_skid_err;
  logic [XLEN-1:0] w_imm;
  logic            w_err;
  logic [31:0]     w_raw;
  logic            w_sext;
  logic [5:0]      w_shamt;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_load_main;
  logic            w_load_skid;
  logic            w_skid_to_main;
  logic            w_unused;

  assign w_unused = &{1'b0, Instr[6:0]};

  // Every format is first built as a 32-bit value, then widened to XLEN.
  always_comb begin
    w_raw   = '0;
    w_sext  = 1'b1;
    w_err   = 1'b0;
    w_shamt = (XLEN == 64) ? Instr[25:20] : {1'b0, Instr[24:20]};
    case (ImmSrc)
      3'b000: w_raw = {{20{Instr[31]}}, Instr[31:20]};
      3'b001: w_raw = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010: w_raw = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      3'b011: w_raw = {Instr[31:12], 12'b0};
      3'b100: w_raw = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      3'b101: begin
        w_raw  = {26'b0, w_shamt};
        w_sext = 1'b0;
      end
      3'b110: begin
        w_raw  = {27'b0, Instr[19:15]};
        w_sext = 1'b0;
      end
      default: begin
        w_raw = '0;
        w_err = 1'b1;
      end
    endcase
    if (w_sext) w_imm = XLEN'($signed(w_raw));
    else        w_imm = XLEN'(w_raw);
  end

  assign in_ready   = (r_state != S_TWO);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign ImmExt     = r_main_imm;
  assign ImmErr     = r_main_err;

  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) begin
          w_next      = S_ONE;
          w_load_main = 1'b1;
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_next = S_EMPTY;
          end
        end
        S_TWO: if (w_out_xfer) begin
          w_next         = S_ONE;
          w_skid_to_main = 1'b1;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_main_imm <= '0;
      r_main_err <= 1'b0;
      r_skid_imm <= '0;
      r_skid_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_main) begin
        r_main_imm <= w_imm;
        r_main_err <= w_err;
      end else if (w_skid_to_main) begin
        r_main_imm <= r_skid_imm;
        r_main_err <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_err <= w_err;
      end
    end
  end

endmodule
